// File: rtl/var_delay_line.sv
// var_delay_line: runtime-programmable delay line.
//
// A ring of MAX_DELAY slots is written every clock at a free-running write pointer; the read
// side trails it by delay_cur slots, so a sample accepted at edge t is presented on the
// registered outputs after edge t+delay_cur. Each slot carries a valid bit so gaps in the input
// stream, and the flush that follows a delay change, show up as out_valid=0 with data_out=0.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (overrides all other inputs)
//   data_in     input sample
//   in_valid    data_in is a real sample this cycle
//   delay_in    requested delay (clamped to 1..MAX_DELAY)
//   delay_load  single-cycle strobe that applies delay_in and flushes the line
//   data_out    delayed sample, 0 when out_valid is low
//   out_valid   data_out carries a real sample
//   delay_cur   delay currently in effect (clamped value)
//   busy        high while the line refills after reset or a delay change
//   delay_err   (only with VAR_DELAY_ERR_EN) sticky flag: a load requested 0 or > MAX_DELAY
//
// Build option: define VAR_DELAY_ERR_EN to add the delay_err output.

module var_delay_line #(
  parameter int unsigned MAX_DELAY  = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned INIT_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH:0]   delay_in,
  input  logic                  delay_load,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic [ADDR_WIDTH:0]   delay_cur,
`ifdef VAR_DELAY_ERR_EN
  output logic                  delay_err,
`endif
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] MaxD  = MAX_DELAY[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] InitD = INIT_DELAY[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] OneD  = 1;

  typedef enum logic {StRun, StFill} state_e;

  state_e                  state;
  logic [DATA_WIDTH-1:0]   mem_data [MAX_DELAY];
  logic [MAX_DELAY-1:0]    mem_vld;
  logic [MAX_DELAY-1:0]    mem_vld_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [ADDR_WIDTH:0]     fill_cnt;
  logic [ADDR_WIDTH:0]     delay_clamped;
  logic                    delay_bad;

  // A requested delay of 0 or beyond the ring depth is out of range.
  always_comb begin
    delay_bad     = (delay_in == '0) || (delay_in > MaxD);
    delay_clamped = delay_in;
    if (delay_in == '0) begin
      delay_clamped = OneD;
    end else if (delay_in > MaxD) begin
      delay_clamped = MaxD;
    end
  end

  // Read slot is delay_cur behind the write slot. For delay_cur == MAX_DELAY the low bits are
  // zero, so the read hits the slot being overwritten this edge; the flop array returns its old
  // contents (read-before-write). For delay_cur == 1 the slot written on the previous edge is read
  // straight from the flops, so no bypass path is needed.
  assign rd_ptr = wr_ptr - delay_cur[ADDR_WIDTH-1:0];

  // A load flushes every slot, but the sample arriving on the load edge is kept.
  always_comb begin
    mem_vld_d = delay_load ? '0 : mem_vld;
    mem_vld_d[wr_ptr] = in_valid;
  end

  // Sample storage needs no reset: the valid bits decide what is real.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_data[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      mem_vld   <= '0;
      delay_cur <= InitD;
      state     <= StFill;
      fill_cnt  <= InitD;
      data_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
      mem_vld <= mem_vld_d;

      // Anything in flight under the old delay is dropped on the load edge.
      if (!delay_load && mem_vld[rd_ptr]) begin
        data_out  <= mem_data[rd_ptr];
        out_valid <= 1'b1;
      end else begin
        data_out  <= '0;
        out_valid <= 1'b0;
      end

      if (delay_load) begin
        delay_cur <= delay_clamped;
        fill_cnt  <= delay_clamped;
        state     <= StFill;
        busy      <= 1'b1;
      end else begin
        unique case (state)
          StFill: begin
            fill_cnt <= fill_cnt - OneD;
            if (fill_cnt == OneD) begin
              state <= StRun;
              busy  <= 1'b0;
            end
          end
          StRun: begin
            busy <= 1'b0;
          end
          default: begin
            state <= StFill;
          end
        endcase
      end
    end
  end

`ifdef VAR_DELAY_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_err <= 1'b0;
    end else if (delay_load && delay_bad) begin
      delay_err <= 1'b1;
    end
  end
`else
  logic unused_delay_bad;
  assign unused_delay_bad = delay_bad;
`endif

endmodule
